// File: rtl/alarm_ringer_pkg.sv
// rtl/alarm_ringer_pkg.sv - shared time widths, ringer state type and minute arithmetic
package alarm_ringer_pkg;

  localparam int TIME_W = 11;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  // Adds n minutes (n < 60) to an {hour, min} time, wrapping at 60 minutes and 24 hours.
  function automatic logic [TIME_W-1:0] add_minutes(input logic [TIME_W-1:0] t,
                                                    input logic [MIN_W-1:0]  n);
    logic [HOUR_W-1:0] h;
    logic [MIN_W:0]    m;
    h = t[TIME_W-1:MIN_W];
    m = {1'b0, t[MIN_W-1:0]} + {1'b0, n};
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = h + 5'd1;
    end
    if (h == 5'd24) begin
      h = 5'd0;
    end
    return {h, m[MIN_W-1:0]};
  endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// rtl/alarm_ringer_if.sv - signals between the alarm and its ringer front end
interface alarm_ringer_if;
  import alarm_ringer_pkg::*;

  logic              ring;
  logic [TIME_W-1:0] time_in;
  logic              tick_1hz;
  logic              end_ring;
  logic              set_time;
  logic [TIME_W-1:0] time_set_out;

  // The alarm side: reports ringing and the time, accepts stop and reload requests.
  modport master (
    output ring, time_in, tick_1hz,
    input  end_ring, set_time, time_set_out
  );

  // The ringer side.
  modport slave (
    input  ring, time_in, tick_1hz,
    output end_ring, set_time, time_set_out
  );

endinterface

// File: rtl/alarm_ringer_beep_gen.sv
// rtl/alarm_ringer_beep_gen.sv - square-wave buzzer pattern, restarts high whenever enabled
module beep_gen #(
  parameter int BEEP_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic buzzer
);

  localparam int CW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  logic [CW-1:0] cnt;
  logic          phase;

  // Half-period counter; phase flips at the end of each half period, both clear while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CW'(BEEP_HALF - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign buzzer = en & ~phase;

endmodule

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - ringing, snooze, dismiss and timeout control for the alarm
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int BEEP_HALF  = 25_000_000,
  parameter int SNOOZE_MIN = 5,
  parameter int TIMEOUT_S  = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic           clk,
  input  logic           rst,
  alarm_ringer_if.slave  bus,
  input  logic           btn_dismiss,
  input  logic           btn_snooze,
  output logic           buzzer,
  output logic           snoozing
);

  localparam int TO_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  state_t            state, state_n;
  logic              ring_q, dis_q, snz_q;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [SC_W-1:0]   snz_cnt, snz_cnt_n;
  logic [TIME_W-1:0] saved, saved_n;
  logic              end_ring_q, end_ring_n;
  logic              set_time_q, set_time_n;
  logic [TIME_W-1:0] tso_q, tso_n;

  logic ring_rise, ring_fall, dis_edge, snz_edge, timeout_hit, give_up;

  assign ring_rise   = bus.ring & ~ring_q;
  assign ring_fall   = ~bus.ring & ring_q;
  assign dis_edge    = btn_dismiss & ~dis_q;
  assign snz_edge    = btn_snooze & ~snz_q;
  assign timeout_hit = bus.tick_1hz && (to_cnt == TO_W'(TIMEOUT_S - 1));
  // An exhausted snooze allowance turns the snooze press into a dismiss.
  assign give_up     = dis_edge || timeout_hit || (snz_edge && (snz_cnt >= SC_W'(MAX_SNOOZE)));

  // State, edge-detect history and registered alarm-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ring_q     <= 1'b0;
      dis_q      <= 1'b0;
      snz_q      <= 1'b0;
      to_cnt     <= '0;
      snz_cnt    <= '0;
      saved      <= '0;
      end_ring_q <= 1'b0;
      set_time_q <= 1'b0;
      tso_q      <= '0;
    end else begin
      state      <= state_n;
      ring_q     <= bus.ring;
      dis_q      <= btn_dismiss;
      snz_q      <= btn_snooze;
      to_cnt     <= to_cnt_n;
      snz_cnt    <= snz_cnt_n;
      saved      <= saved_n;
      end_ring_q <= end_ring_n;
      set_time_q <= set_time_n;
      tso_q      <= tso_n;
    end
  end

  // Next state and next values of the pulses, reload time and bookkeeping.
  always_comb begin
    state_n    = state;
    snz_cnt_n  = snz_cnt;
    saved_n    = saved;
    end_ring_n = 1'b0;
    set_time_n = 1'b0;
    tso_n      = tso_q;
    to_cnt_n   = '0;
    case (state)
      IDLE: begin
        if (ring_rise) begin
          state_n   = RINGING;
          saved_n   = bus.time_in;
          snz_cnt_n = '0;
        end
      end
      RINGING: begin
        if (give_up) begin
          state_n    = IDLE;
          end_ring_n = 1'b1;
          if (snz_cnt != '0) begin
            set_time_n = 1'b1;
            tso_n      = saved;
          end
        end else if (snz_edge) begin
          state_n    = SNOOZED;
          end_ring_n = 1'b1;
          set_time_n = 1'b1;
          tso_n      = add_minutes(bus.time_in, MIN_W'(SNOOZE_MIN));
          snz_cnt_n  = snz_cnt + 1'b1;
        end else if (ring_fall) begin
          // The alarm stopped on its own; put the original time back if we moved it.
          state_n = IDLE;
          if (snz_cnt != '0) begin
            set_time_n = 1'b1;
            tso_n      = saved;
          end
        end else begin
          to_cnt_n = bus.tick_1hz ? to_cnt + 1'b1 : to_cnt;
        end
      end
      SNOOZED: begin
        if (dis_edge) begin
          state_n    = IDLE;
          set_time_n = 1'b1;
          tso_n      = saved;
        end else if (ring_rise) begin
          state_n = RINGING;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  beep_gen #(.BEEP_HALF(BEEP_HALF)) u_beep (
    .clk    (clk),
    .rst    (rst),
    .en     (state == RINGING),
    .buzzer (buzzer)
  );

  assign snoozing         = (state == SNOOZED);
  assign bus.end_ring     = end_ring_q;
  assign bus.set_time     = set_time_q;
  assign bus.time_set_out = tso_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed, table and randomized checks of alarm_ringer
module tb_alarm_ringer;

  localparam int BH = 3;
  localparam int SM = 5;
  localparam int TO = 60;
  localparam int MS = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_dismiss;
  logic btn_snooze;
  logic buzzer;
  logic snoozing;

  alarm_ringer_if aif ();

  alarm_ringer #(.BEEP_HALF(BH), .SNOOZE_MIN(SM), .TIMEOUT_S(TO), .MAX_SNOOZE(MS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (aif),
    .btn_dismiss (btn_dismiss),
    .btn_snooze  (btn_snooze),
    .buzzer      (buzzer),
    .snoozing    (snoozing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int n_end    = 0;
  int n_set    = 0;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozed; times held as hour/minute words.
  int          m_mode, m_snoozes, m_ticks, m_ring_cyc;
  logic [10:0] m_saved, m_tso;
  bit          m_end, m_set, m_ring_d, m_dis_d, m_snz_d;

  function automatic logic [10:0] mk(input int h, input int m);
    return 11'(h * 64 + m);
  endfunction

  function automatic logic [10:0] plus_snooze(input logic [10:0] t);
    int tot;
    tot = (int'(t[10:6]) * 60 + int'(t[5:0]) + SM) % 1440;
    return mk(tot / 60, tot % 60);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_snoozes = 0; m_ticks = 0; m_ring_cyc = 0;
    m_saved = '0; m_tso = '0; m_end = 0; m_set = 0;
    m_ring_d = 0; m_dis_d = 0; m_snz_d = 0;
  endtask

  task automatic model_step();
    bit rr, rf, de, se;
    rr = aif.ring && !m_ring_d;
    rf = !aif.ring && m_ring_d;
    de = btn_dismiss && !m_dis_d;
    se = btn_snooze && !m_snz_d;
    m_end = 0;
    m_set = 0;
    if (m_mode == 0) begin
      if (rr) begin
        m_mode = 1; m_saved = aif.time_in; m_snoozes = 0; m_ticks = 0; m_ring_cyc = 0;
      end
    end else if (m_mode == 1) begin
      if (de || (aif.tick_1hz && m_ticks + 1 >= TO) || (se && m_snoozes >= MS)) begin
        m_mode = 0; m_end = 1;
        if (m_snoozes > 0) begin m_set = 1; m_tso = m_saved; end
      end else if (se) begin
        m_mode = 2; m_end = 1; m_set = 1; m_tso = plus_snooze(aif.time_in); m_snoozes++;
      end else if (rf) begin
        m_mode = 0;
        if (m_snoozes > 0) begin m_set = 1; m_tso = m_saved; end
      end else begin
        m_ring_cyc++;
        if (aif.tick_1hz) m_ticks++;
      end
    end else begin
      if (de) begin
        m_mode = 0; m_set = 1; m_tso = m_saved;
      end else if (rr) begin
        m_mode = 1; m_ticks = 0; m_ring_cyc = 0;
      end
    end
    m_ring_d = aif.ring;
    m_dis_d  = btn_dismiss;
    m_snz_d  = btn_snooze;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT samples at the edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  // Continuous comparison against the model, plus pulse bookkeeping for the directed tests.
  always @(negedge clk) begin
    if (chk_en) begin
      check("end_ring", 32'(aif.end_ring), 32'(m_end));
      check("set_time", 32'(aif.set_time), 32'(m_set));
      check("time_set_out", 32'(aif.time_set_out), 32'(m_tso));
      check("buzzer", 32'(buzzer), 32'(m_mode == 1 && ((m_ring_cyc / BH) % 2 == 0)));
      check("snoozing", 32'(snoozing), 32'(m_mode == 2));
    end
    if (aif.end_ring === 1'b1) n_end++;
    if (aif.set_time === 1'b1) n_set++;
  end

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    aif.ring = 0; aif.tick_1hz = 0; aif.time_in = '0;
    btn_dismiss = 0; btn_snooze = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    n_end = 0;
    n_set = 0;
  endtask

  task automatic pulse_tick();
    aif.tick_1hz = 1'b1;
    cyc();
    aif.tick_1hz = 1'b0;
  endtask

  typedef struct {
    logic [10:0] t;
    logic [10:0] exp;
  } snooze_vec_t;

  snooze_vec_t vecs[6];

  initial begin
    vecs[0] = '{mk(7, 30),  mk(7, 35)};
    vecs[1] = '{mk(23, 58), mk(0, 3)};
    vecs[2] = '{mk(10, 57), mk(11, 2)};
    vecs[3] = '{mk(12, 55), mk(13, 0)};
    vecs[4] = '{mk(23, 59), mk(0, 4)};
    vecs[5] = '{mk(0, 0),   mk(0, 5)};

    do_reset();
    chk_en = 1'b1;

    // Reset state
    check("reset_end_ring", 32'(aif.end_ring), 0);
    check("reset_set_time", 32'(aif.set_time), 0);
    check("reset_tso", 32'(aif.time_set_out), 0);
    check("reset_buzzer", 32'(buzzer), 0);
    check("reset_snoozing", 32'(snoozing), 0);

    // Unanswered ringing times out after TO ticks
    aif.time_in = mk(7, 30);
    aif.ring = 1;
    cyc();
    check("t1_buzzer_start", 32'(buzzer), 1);
    cyc(); cyc(); cyc();
    check("t1_buzzer_half", 32'(buzzer), 0);
    for (int i = 0; i < TO - 1; i++) begin
      pulse_tick();
      cyc();
    end
    check("t1_no_end_before_timeout", 32'(n_end), 0);
    pulse_tick();
    check("t1_end_pulse", 32'(aif.end_ring), 1);
    aif.ring = 0;
    cyc(); cyc();
    check("t1_end_count", 32'(n_end), 1);
    check("t1_set_count", 32'(n_set), 0);
    check("t1_buzzer_off", 32'(buzzer), 0);
    check("t1_not_snoozing", 32'(snoozing), 0);

    // Snooze then dismiss restores the original time
    do_reset();
    aif.time_in = mk(7, 30);
    aif.ring = 1;
    cyc();
    btn_snooze = 1;
    cyc();
    check("t2_snz_end", 32'(aif.end_ring), 1);
    check("t2_snz_set", 32'(aif.set_time), 1);
    check("t2_snz_tso", 32'(aif.time_set_out), 32'(mk(7, 35)));
    check("t2_snoozing", 32'(snoozing), 1);
    btn_snooze = 0;
    aif.ring = 0;
    cyc();
    check("t2_end_one_cycle", 32'(aif.end_ring), 0);
    check("t2_tso_held", 32'(aif.time_set_out), 32'(mk(7, 35)));
    aif.time_in = mk(7, 35);
    aif.ring = 1;
    cyc();
    check("t2_reringing", 32'(snoozing), 0);
    btn_dismiss = 1;
    cyc();
    check("t2_dis_end", 32'(aif.end_ring), 1);
    check("t2_dis_set", 32'(aif.set_time), 1);
    check("t2_dis_tso", 32'(aif.time_set_out), 32'(mk(7, 30)));
    btn_dismiss = 0;
    aif.ring = 0;
    cyc();

    // Snooze minute-add table, including hour and midnight wrap
    foreach (vecs[i]) begin
      do_reset();
      aif.time_in = vecs[i].t;
      aif.ring = 1;
      cyc();
      btn_snooze = 1;
      cyc();
      check($sformatf("tbl%0d_set", i), 32'(aif.set_time), 1);
      check($sformatf("tbl%0d_tso", i), 32'(aif.time_set_out), 32'(vecs[i].exp));
      btn_snooze = 0;
      aif.ring = 0;
      cyc();
    end

    // Snooze limit: the snooze after MS snoozes acts as dismiss, count restarts next event
    do_reset();
    aif.time_in = mk(7, 30);
    aif.ring = 1;
    cyc();
    for (int i = 0; i < MS; i++) begin
      btn_snooze = 1;
      cyc();
      check($sformatf("t4_snz%0d_set", i), 32'(aif.set_time), 1);
      check($sformatf("t4_snz%0d_tso", i), 32'(aif.time_set_out), 32'(mk(7, 35)));
      check($sformatf("t4_snz%0d_snoozing", i), 32'(snoozing), 1);
      btn_snooze = 0;
      aif.ring = 0;
      cyc();
      aif.ring = 1;
      cyc();
    end
    btn_snooze = 1;
    cyc();
    check("t4_limit_end", 32'(aif.end_ring), 1);
    check("t4_limit_set", 32'(aif.set_time), 1);
    check("t4_limit_tso", 32'(aif.time_set_out), 32'(mk(7, 30)));
    check("t4_limit_not_snoozing", 32'(snoozing), 0);
    btn_snooze = 0;
    aif.ring = 0;
    cyc();
    aif.time_in = mk(8, 0);
    aif.ring = 1;
    cyc();
    btn_snooze = 1;
    cyc();
    check("t4_new_event_snoozing", 32'(snoozing), 1);
    check("t4_new_event_tso", 32'(aif.time_set_out), 32'(mk(8, 5)));
    btn_snooze = 0;
    aif.ring = 0;
    cyc();

    // Dismiss and snooze together: dismiss only
    do_reset();
    aif.time_in = mk(6, 15);
    aif.ring = 1;
    cyc();
    btn_dismiss = 1;
    btn_snooze = 1;
    cyc();
    check("t5_end", 32'(aif.end_ring), 1);
    check("t5_no_set", 32'(aif.set_time), 0);
    check("t5_not_snoozing", 32'(snoozing), 0);
    btn_dismiss = 0;
    btn_snooze = 0;
    aif.ring = 0;
    cyc();

    // Reset while snoozed clears everything at once
    do_reset();
    aif.time_in = mk(9, 0);
    aif.ring = 1;
    cyc();
    btn_snooze = 1;
    cyc();
    btn_snooze = 0;
    aif.ring = 0;
    rst = 1;
    model_reset();
    #1;
    check("t6_rst_snoozing", 32'(snoozing), 0);
    check("t6_rst_end", 32'(aif.end_ring), 0);
    check("t6_rst_set", 32'(aif.set_time), 0);
    check("t6_rst_tso", 32'(aif.time_set_out), 0);
    cyc();
    rst = 0;
    cyc();
    aif.ring = 1;
    cyc();
    for (int i = 0; i < MS; i++) begin
      btn_snooze = 1;
      cyc();
      check($sformatf("t6_snz%0d_snoozing", i), 32'(snoozing), 1);
      btn_snooze = 0;
      aif.ring = 0;
      cyc();
      aif.ring = 1;
      cyc();
    end
    aif.ring = 0;
    cyc();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) aif.ring = ~aif.ring;
      if (aif.end_ring && $urandom_range(3) != 0) aif.ring = 0;
      if ($urandom_range(15) == 0) btn_dismiss = ~btn_dismiss;
      if ($urandom_range(9) == 0) btn_snooze = ~btn_snooze;
      aif.tick_1hz = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) aif.time_in = mk($urandom_range(23), $urandom_range(59));
      if ($urandom_range(999) == 0) begin
        rst = 1;
        model_reset();
      end else begin
        rst = 0;
      end
      cyc();
    end
    rst = 0;
    cyc();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
